deal_scheduler: RTL

// Shares the single card source between the player and dealer hand controllers. Arbitrates their draw

---
 rtl/deal_scheduler.sv | 117 +++++++++++
 1 files changed

// File: rtl/deal_scheduler.sv
// Card deal scheduler: arbitrates player/dealer draws and deals unique cards per round.
// Optional AUTO_RESHUFFLE_EN: an empty deck reshuffles itself on the next request.
module deal_scheduler #(
   parameter int DECK_SIZE = 52,
   parameter int IDX_W     = 6
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_shuffle,
   input  logic             i_playerReq,
   input  logic             i_dealerReq,
   input  logic [IDX_W-1:0] i_rngValue,
   output logic             o_rngAdvance,
   output logic [IDX_W-1:0] o_card,
   output logic             o_playerGrant,
   output logic             o_dealerGrant,
   output logic             o_busy,
   output logic             o_deckEmpty
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SAMPLE = 2'd1;
   localparam logic [1:0] PROBE  = 2'd2;
   localparam logic [1:0] GRANT  = 2'd3;

   localparam logic [IDX_W:0]   DS_W = (IDX_W+1)'(DECK_SIZE);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DECK_SIZE - 1);

   logic [1:0]           state;
   logic [DECK_SIZE-1:0] mask;
   logic [IDX_W:0]       count;
   logic [IDX_W-1:0]     cand;
   logic                 dest;
   logic                 last_served;
   logic                 deck_empty;
   logic [IDX_W:0]       rng_ext;
   logic                 any_req;
   logic                 win_dealer;
   logic                 full;
   logic                 grant_ok;

   // dest/last_served encoding: 0 = player, 1 = dealer
   assign any_req    = i_playerReq | i_dealerReq;
   assign win_dealer = i_dealerReq & (~i_playerReq | ~last_served);
   assign full       = (count == DS_W);
   assign rng_ext    = {1'b0, i_rngValue};
   assign grant_ok   = (state == GRANT) & ~i_shuffle & ~i_reset;

   assign o_playerGrant = grant_ok & ~dest;
   assign o_dealerGrant = grant_ok & dest;
   assign o_card        = grant_ok ? cand : '0;
   assign o_rngAdvance  = (state == SAMPLE) & ~i_shuffle & ~i_reset;
   assign o_busy        = (state != IDLE);
   assign o_deckEmpty   = deck_empty;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         mask        <= '0;
         count       <= '0;
         cand        <= '0;
         dest        <= 1'b0;
         last_served <= 1'b1;
         deck_empty  <= 1'b0;
      end else if (i_shuffle) begin
         state      <= IDLE;
         mask       <= '0;
         count      <= '0;
         deck_empty <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
`ifdef AUTO_RESHUFFLE_EN
               if (any_req) begin
                  dest  <= win_dealer;
                  state <= SAMPLE;
                  if (full) begin
                     mask       <= '0;
                     count      <= '0;
                     deck_empty <= 1'b0;
                  end
               end
`else
               if (any_req && !full) begin
                  dest  <= win_dealer;
                  state <= SAMPLE;
               end
`endif
            end
            SAMPLE: begin
               if (rng_ext >= DS_W)
                  cand <= IDX_W'(rng_ext - DS_W);
               else
                  cand <= i_rngValue;
               state <= PROBE;
            end
            PROBE: begin
               if (!mask[cand])
                  state <= GRANT;
               else if (cand == LAST)
                  cand <= '0;
               else
                  cand <= cand + 1'b1;
            end
            GRANT: begin
               mask[cand]  <= 1'b1;
               count       <= count + 1'b1;
               deck_empty  <= ((count + 1'b1) == DS_W);
               last_served <= dest;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
